if_id_reg: RTL
==============

# if_id_reg

IF/ID pipeline register for the 32-bit MIPS datapath. Captures the fetched instruction and PC+4 at the end of IF and presents them to ID. Pre-decodes the fields consumed by the ID-stage extenders and registers them alongside the instruction, so they are valid at the start of ID:
- 16-bit immediate and ExtOp for the 16-bit extender.
- shamt for the 5-bit zero-extender.

Supports stall (hold), flush (bubble) and a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- WIDTH, 32, datapath width of instruction and PC fields.
- CNT_W, 8, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous reset, active high.
- stall  input  1  hold all registers (hazard unit).
- flush  input  1  replace contents with a bubble (branch/jump taken).
- valid_in  input  1  IF has a real instruction this cycle.
- instr_in  input  WIDTH  fetched instruction.
- pc4_in  input  WIDTH  PC+4 of fetched instruction.
- valid_out  output  1  ID holds a real instruction.
- instr_out  output  WIDTH  registered instruction.
- pc4_out  output  WIDTH  registered PC+4.
- imm16  output  16  instr[15:0] of the registered instruction.
- shamt  output  5  instr[10:6] of the registered instruction.
- ext_op  output  1  1 = sign-extend imm16, 0 = zero-extend.
- stall_cnt  output  CNT_W  saturating count of stalled cycles with valid_out=1.

## Operation
- Priority at each rising edge: rst > flush > stall > load.
- rst:
  - instr_out=0 (sll $0,$0,0 = NOP), pc4_out=0, valid_out=0.
  - imm16=0, shamt=0, ext_op=0, stall_cnt=0.
- flush:
  - Same register values as rst, except stall_cnt is preserved.
  - flush with stall=1 still flushes.
- stall (flush=0): every register holds, except stall_cnt.
- load (no rst, flush or stall):
  - instr_out←instr_in, pc4_out←pc4_in, valid_out←valid_in.
  - Decoded fields are computed from instr_in in the same edge.
  - If valid_in=0, the instruction is still loaded but valid_out=0, and ext_op, imm16 and shamt are forced to 0.
- ext_op decode on opcode instr[31:26]:
  - 1 for 0x04 beq, 0x05 bne, 0x06 blez, 0x07 bgtz, 0x01 REGIMM.
  - 1 for 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu.
  - 1 for 0x20–0x25 loads and 0x28, 0x29, 0x2B stores.
  - 0 for 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, R-type 0x00, J-type 0x02/0x03, and all others.
- imm16 = instr_in[15:0] and shamt = instr_in[10:6], unconditionally on load.
  - They are raw fields; the extenders select them.
- stall_cnt:
  - Increments by 1 on every edge where stall=1, flush=0, rst=0 and valid_out=1.
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by rst.
- Outputs are purely registered; no combinational path from any input to any output.

## Timing
- Latency: 1 cycle from instr_in to instr_out and the decoded fields.
- Stall behaviour:
  - Stall asserted in cycle N freezes the outputs seen in cycle N+1.
  - Deasserting in cycle M loads instr_in at edge M; new values are visible in M+1.
- Flush asserted in cycle N: valid_out=0 and instr_out=0 in cycle N+1.
- rst asserted mid-stall or mid-flush: all outputs hold reset values from the next cycle. The first load occurs on the first edge with rst=0 and stall=0.
- Back-to-back loads sustain one instruction per cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with instr_in=0x2008FFFF, valid_in=1 -> instr_out=0, valid_out=0, ext_op=0, stall_cnt=0.
- Load/decode:
  - Load addi 0x2008FFFF -> next cycle imm16=0xFFFF, ext_op=1, valid_out=1.
  - Then load ori 0x3508FFFF -> ext_op=0, imm16=0xFFFF.
  - Then load sll 0x00084080 -> shamt=2, ext_op=0.
- Stall: load lw 0x8D090004, then stall for 3 cycles while instr_in changes -> instr_out stays 0x8D090004 and stall_cnt=3. Releasing stall loads the new instr_in one edge later.
- Flush priority: stall=1 and flush=1 on the same edge after beq 0x1109000A is loaded -> valid_out=0, instr_out=0, ext_op=0, stall_cnt unchanged.
- Saturation: with CNT_W=2, stall 6 cycles with valid_out=1 -> stall_cnt reaches 3 and stays at 3. rst then clears it to 0.
- Invalid fetch: valid_in=0 with instr_in=0x2008FFFF -> valid_out=0, ext_op=0, imm16=0. stall_cnt does not increment while stalling on that bubble.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with operand pre-decode.
// Holds instruction, PC+4 and extender fields for ID.
module if_id_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] pc4_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc4_out,
  output logic [15:0]      imm16,
  output logic [4:0]       shamt,
  output logic             ext_op,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic [15:0]      imm_q, imm_d;
  logic [4:0]       shamt_q, shamt_d;
  logic             ext_q, ext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_dec;
  logic             cnt_max;

  // Sign-extend for branches, arithmetic immediates and memory offsets.
  always_comb begin
    ext_dec = 1'b0;
    case (instr_in[31:26])
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: ext_dec = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B:        ext_dec = 1'b1;
      6'h20, 6'h21, 6'h22, 6'h23:        ext_dec = 1'b1;
      6'h24, 6'h25:                      ext_dec = 1'b1;
      6'h28, 6'h29, 6'h2B:               ext_dec = 1'b1;
      default:                           ext_dec = 1'b0;
    endcase
  end

  assign cnt_max = &cnt_q;

  // Next state: flush beats stall beats load; counter survives flush.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    imm_d   = imm_q;
    shamt_d = shamt_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc4_d   = '0;
      imm_d   = '0;
      shamt_d = '0;
      ext_d   = 1'b0;
    end else if (stall) begin
      if (valid_q && !cnt_max)
        cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d = valid_in;
      instr_d = instr_in;
      pc4_d   = pc4_in;
      imm_d   = valid_in ? instr_in[15:0] : 16'h0;
      shamt_d = valid_in ? instr_in[10:6] : 5'h0;
      ext_d   = valid_in & ext_dec;
    end
  end

  // State registers with synchronous reset to a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
      ext_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      imm_q   <= imm_d;
      shamt_q <= shamt_d;
      ext_q   <= ext_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out = valid_q;
  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign imm16     = imm_q;
  assign shamt     = shamt_q;
  assign ext_op    = ext_q;
  assign stall_cnt = cnt_q;

endmodule
